// File: rtl/mb_rx.sv
// mb_rx: mainband receiver that deserialises DDR lane samples into 64-byte flits and buffers them.
module mb_rx #(
  parameter int FLIT_BUF_DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [15:0]  data_rise_i,
  input  logic [15:0]  data_fall_i,
  input  logic         valid_rise_i,
  input  logic         valid_fall_i,
  output logic [511:0] flit_o,
  output logic         flit_valid_o,
  input  logic         flit_ready_i,
  output logic         receiving_o,
  output logic         frame_err_o,
  output logic         overflow_o,
  output logic [7:0]   err_count_o
);
  localparam int AW = $clog2(FLIT_BUF_DEPTH);
  typedef enum logic {IDLE, RX} state_t;
  state_t state, state_n;
  logic [1:0] g, p, g_n, p_n, pair;
  logic match, cap, mism, commit, pop, push, empty, full;
  logic [511:0] asm_q, asm_n;
  logic [511:0] mem [FLIT_BUF_DEPTH];
  logic [AW:0] wp, rp;
  assign pair = {valid_rise_i, valid_fall_i};
  assign match = pair == (p[1] ? 2'b00 : 2'b11);
  assign cap = (state == IDLE) ? pair == 2'b11 : match;
  assign mism = state == RX && !match;
  assign commit = state == RX && match && g == 2'd3 && p == 2'd3;
  // state register; g and p stay zero in IDLE so a new flit starts at g=0, p=0
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      g <= '0;
      p <= '0;
    end else begin
      state <= state_n;
      g <= g_n;
      p <= p_n;
    end
  // next state: advance on matching pairs, fall back to IDLE on mismatch or commit
  always_comb begin
    state_n = state;
    g_n = g;
    p_n = p;
    if (state == IDLE) begin
      state_n = cap ? RX : IDLE;
      p_n = cap ? 2'd1 : 2'd0;
    end else if (!match || commit) begin
      state_n = IDLE;
      g_n = '0;
      p_n = '0;
    end else begin
      p_n = p + 2'd1;
      g_n = g + {1'b0, p == 2'd3};
    end
  end
  // outputs derived from state
  always_comb receiving_o = state == RX;
  // merge this cycle's samples: lane k bit pair lands in byte g*16+k at bits 2p/2p+1
  always_comb begin
    asm_n = asm_q;
    for (int k = 0; k < 16; k++) begin
      asm_n[{g, 4'(k), p, 1'b0}] = data_rise_i[k];
      asm_n[{g, 4'(k), p, 1'b1}] = data_fall_i[k];
    end
  end
  // assembly register; every bit is rewritten by a complete flit so no clear is needed
  always_ff @(posedge clk)
    if (cap) asm_q <= asm_n;
  assign empty = wp == rp;
  assign full = (wp ^ rp) == {1'b1, {AW{1'b0}}};
  assign pop = !empty && flit_ready_i;
  assign push = commit && (!full || pop);
  assign flit_valid_o = !empty;
  assign flit_o = empty ? '0 : mem[rp[AW-1:0]];
  // FIFO pointers with wrap bit
  always_ff @(posedge clk)
    if (reset) begin
      wp <= '0;
      rp <= '0;
    end else begin
      wp <= wp + (AW+1)'(push);
      rp <= rp + (AW+1)'(pop);
    end
  // FIFO storage; on full-with-pop the freed head slot is the one written
  always_ff @(posedge clk)
    if (push) mem[wp[AW-1:0]] <= asm_n;
  // error/overflow pulses and saturating framing error counter
  always_ff @(posedge clk)
    if (reset) begin
      frame_err_o <= 1'b0;
      overflow_o <= 1'b0;
      err_count_o <= '0;
    end else begin
      frame_err_o <= mism;
      overflow_o <= commit && full && !pop;
      if (mism && err_count_o != 8'hFF) err_count_o <= err_count_o + 8'd1;
    end
endmodule

// File: tb/tb_mb_rx.sv
// tb_mb_rx: table-driven and scoreboarded checks of the mb_rx flit receiver.
module tb_mb_rx;
  logic clk = 0, reset = 1;
  logic [15:0] data_rise_i = 0, data_fall_i = 0;
  logic valid_rise_i = 0, valid_fall_i = 0, flit_ready_i = 0;
  logic [511:0] flit_o;
  logic flit_valid_o, receiving_o, frame_err_o, overflow_o;
  logic [7:0] err_count_o;
  typedef struct {
    logic [511:0] f;
    int bad_cyc;
    logic [1:0] bad_pair;
  } vec_t;
  vec_t tbl[7];
  logic [511:0] q[$];
  logic [511:0] inc, rnd;
  int checks = 0, errors = 0, exp_err = 0;
  mb_rx #(.FLIT_BUF_DEPTH(2)) dut (
    .clk(clk), .reset(reset), .data_rise_i(data_rise_i), .data_fall_i(data_fall_i),
    .valid_rise_i(valid_rise_i), .valid_fall_i(valid_fall_i), .flit_o(flit_o),
    .flit_valid_o(flit_valid_o), .flit_ready_i(flit_ready_i), .receiving_o(receiving_o),
    .frame_err_o(frame_err_o), .overflow_o(overflow_o), .err_count_o(err_count_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [511:0] a, input logic [511:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  function automatic logic [511:0] fill(input logic [7:0] b);
    return {64{b}};
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  // drive one flit on the wire; optionally corrupt a cycle, raise ready or pulse reset at a chosen cycle
  task automatic send(input logic [511:0] f, input int bad_cyc = -1, input logic [1:0] bad_pair = 2'b00,
                      input int rdy_at = -1, input int rst_at = -1);
    int g, p;
    for (int c = 0; c < 16; c++) begin
      g = c / 4;
      p = c % 4;
      for (int k = 0; k < 16; k++) begin
        data_rise_i[k] = f[(g*16+k)*8 + 2*p];
        data_fall_i[k] = f[(g*16+k)*8 + 2*p + 1];
      end
      {valid_rise_i, valid_fall_i} = (c == bad_cyc) ? bad_pair : (p < 2 ? 2'b11 : 2'b00);
      if (c == rdy_at) flit_ready_i = 1;
      reset = (c == rst_at);
      step();
      reset = 0;
      if (c == bad_cyc || c == rst_at) break;
      if (c < 15) chk("receiving_mid", receiving_o, 1);
    end
    {valid_rise_i, valid_fall_i} = 2'b00;
    data_rise_i = 0;
    data_fall_i = 0;
  endtask
  // scoreboard: every accepted pop must match the oldest expected flit
  always @(negedge clk)
    if (!reset && flit_valid_o && flit_ready_i) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected: got %0h expected no flit", flit_o);
      end else begin
        logic [511:0] e;
        e = q.pop_front();
        if (flit_o !== e) begin
          errors++;
          $display("FAIL pop_data: got %0h expected %0h", flit_o, e);
        end
      end
    end
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
  initial begin
    for (int i = 0; i < 64; i++) inc[i*8 +: 8] = 8'(i);
    for (int i = 0; i < 16; i++) rnd[i*32 +: 32] = $urandom;
    tbl[0] = '{inc, -1, 2'b00};
    tbl[1] = '{fill(8'hC3), 5, 2'b10};
    tbl[2] = '{rnd, -1, 2'b00};
    tbl[3] = '{fill(8'h5A), 2, 2'b11};
    tbl[4] = '{fill(8'hF0), 15, 2'b01};
    tbl[5] = '{fill(8'h0F), 4, 2'b00};
    tbl[6] = '{fill(8'hFF), -1, 2'b00};
    repeat (2) step();
    reset = 0;
    chk("rst_valid", flit_valid_o, 0);
    chk("rst_flit", flit_o, 0);
    chk("rst_receiving", receiving_o, 0);
    chk("rst_frame_err", frame_err_o, 0);
    chk("rst_overflow", overflow_o, 0);
    chk("rst_err_count", err_count_o, 0);
    // idle pairs 01/10/00 are ignored
    {valid_rise_i, valid_fall_i} = 2'b10;
    step();
    {valid_rise_i, valid_fall_i} = 2'b01;
    step();
    {valid_rise_i, valid_fall_i} = 2'b00;
    chk("idle_ignore_rx", receiving_o, 0);
    chk("idle_ignore_err", frame_err_o, 0);
    flit_ready_i = 1;
    foreach (tbl[i]) begin
      logic ok;
      ok = tbl[i].bad_cyc < 0;
      if (ok) q.push_back(tbl[i].f);
      else exp_err++;
      send(tbl[i].f, tbl[i].bad_cyc, tbl[i].bad_pair);
      chk("tbl_frame_err", frame_err_o, !ok);
      chk("tbl_flit_valid", flit_valid_o, ok);
      chk("tbl_receiving", receiving_o, 0);
      chk("tbl_overflow", overflow_o, 0);
      chk("tbl_err_count", err_count_o, exp_err);
      step();
      chk("tbl_err_pulse", frame_err_o, 0);
      chk("tbl_valid_popped", flit_valid_o, 0);
    end
    // back-to-back into full buffer, then overflow
    flit_ready_i = 0;
    q.push_back(fill(8'hA5));
    q.push_back(fill(8'h3C));
    send(fill(8'hA5));
    send(fill(8'h3C));
    chk("b2b_valid", flit_valid_o, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("b2b_stable", flit_o, fill(8'hA5));
    end
    send(fill(8'h77));
    chk("ovf_pulse", overflow_o, 1);
    step();
    chk("ovf_clear", overflow_o, 0);
    chk("ovf_head", flit_o, fill(8'hA5));
    flit_ready_i = 1;
    repeat (3) step();
    chk("ovf_drained", flit_valid_o, 0);
    // 1-cycle gap, then commit into full buffer with a simultaneous pop
    flit_ready_i = 0;
    q.push_back(fill(8'h11));
    q.push_back(fill(8'h22));
    send(fill(8'h11));
    step();
    send(fill(8'h22));
    chk("gap_valid", flit_valid_o, 1);
    q.push_back(fill(8'h33));
    send(fill(8'h33), -1, 2'b00, 15);
    chk("fullpop_no_ovf", overflow_o, 0);
    repeat (3) step();
    chk("fullpop_drained", flit_valid_o, 0);
    // reset in the middle of a flit
    send(fill(8'h99), -1, 2'b00, -1, 8);
    chk("midrst_receiving", receiving_o, 0);
    chk("midrst_frame_err", frame_err_o, 0);
    chk("midrst_valid", flit_valid_o, 0);
    chk("midrst_err_count", err_count_o, 0);
    exp_err = 0;
    step();
    chk("midrst_err_after", frame_err_o, 0);
    q.push_back(fill(8'h5E));
    send(fill(8'h5E));
    chk("midrst_next_valid", flit_valid_o, 1);
    step();
    // saturation of the error counter
    for (int n = 1; n <= 300; n++) begin
      send(fill(8'h00), 1, 2'b00);
      exp_err = n > 255 ? 255 : n;
      if (n == 1 || (n >= 254 && n <= 257) || n == 300) chk("sat_err_count", err_count_o, exp_err);
    end
    step();
    chk("sat_no_flit", flit_valid_o, 0);
    chk("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mb_rx.md
MB_RX -- requirements
Module: mb_rx

Interface
REQ-001 Parameter FLIT_BUF_DEPTH, default 2, is the number of received-flit buffer entries; it SHALL be a power of two and at least 2.
REQ-002 clk  input  1  fast mainband clock; each cycle carries 2 UI (rising-edge and falling-edge samples).
REQ-003 reset  input  1  synchronous, active-high reset; clock clk.
REQ-004 data_rise_i  input  16  lane samples of the first UI of the cycle, from the DDR IO cells.
REQ-005 data_fall_i  input  16  lane samples of the second UI of the cycle.
REQ-006 valid_rise_i  input  1  valid-pin sample of the first UI.
REQ-007 valid_fall_i  input  1  valid-pin sample of the second UI.
REQ-008 flit_o  output  512  head flit; byte b SHALL be at bits [8b+7:8b].
REQ-009 flit_valid_o  output  1  buffer non-empty; flit_o is valid.
REQ-010 flit_ready_i  input  1  consumer accepts the head flit.
REQ-011 receiving_o  output  1  high while a flit is being assembled.
REQ-012 frame_err_o  output  1  one-cycle pulse on a valid-framing violation.
REQ-013 overflow_o  output  1  one-cycle pulse when a completed flit is dropped because the buffer is full.
REQ-014 err_count_o  output  8  count of framing errors, saturating at 255.

Function
REQ-015 The wire format SHALL be as follows: 64-byte flit = 4 groups x 16 lanes; group g is 8 UI = 4 cycles; lane k in group g carries byte g*16+k, LSB first.
REQ-016 Within group phase p (0..3), data_rise_i[k] SHALL be stored as bit 2p and data_fall_i[k] as bit 2p+1 of byte g*16+k.
REQ-017 The expected valid pair {rise,fall} per phase SHALL be: p0 11, p1 11, p2 00, p3 00.
REQ-018 The FSM SHALL have two states, IDLE and RX; RX tracks group g (2-bit) and phase p (2-bit).
REQ-019 In IDLE, a valid pair of 11 SHALL enter RX; that same cycle is captured as g=0, p=0.
REQ-020 In IDLE, pairs of 00, 01 and 10 SHALL be ignored with no error.
REQ-021 In RX, each cycle SHALL compare the valid pair to the expected value for phase p.
REQ-022 On a match, RX SHALL capture the data and advance p; on p wrap, g SHALL advance.
REQ-023 On a mismatch, RX SHALL pulse frame_err_o, increment err_count_o, discard the partial flit, and return to IDLE; the mismatching cycle SHALL NOT start a new flit.
REQ-024 When g=3, p=3 is captured with a match, the flit SHALL be committed and the FSM SHALL return to IDLE.
REQ-025 An 11 pair on the next cycle after a commit SHALL start the next flit, so back-to-back flits have no gap.
REQ-026 A 1-cycle idle gap between flits SHALL also be accepted.
REQ-027 receiving_o SHALL equal (state==RX).
REQ-028 The buffer SHALL be a FIFO with write/read pointers of log2(FLIT_BUF_DEPTH) bits plus wrap bit; pointers SHALL wrap modulo depth.
REQ-029 flit_valid_o SHALL be high iff the buffer is non-empty; flit_o SHALL show the head entry, or 0 when empty.
REQ-030 A pop SHALL occur on a clock edge with flit_valid_o & flit_ready_i.
REQ-031 flit_o SHALL remain stable while flit_valid_o & !flit_ready_i.
REQ-032 Latency: flit_valid_o SHALL assert in the cycle immediately after the edge that captures g=3/p=3, when the buffer was empty.
REQ-033 Commit to a full buffer with no simultaneous pop SHALL drop the flit and pulse overflow_o; buffer contents SHALL be unchanged.
REQ-034 Commit to a full buffer with a simultaneous pop SHALL be accepted, with no overflow.
REQ-035 flit_ready_i while empty SHALL have no effect.
REQ-036 err_count_o SHALL hold at 255 once reached.

Reset
REQ-037 While reset is high at a clk edge, the FSM SHALL go to IDLE and g, p and the FIFO pointers SHALL clear.
REQ-038 After reset: flit_valid_o=0, flit_o=0, receiving_o=0, frame_err_o=0, overflow_o=0, err_count_o=0.
REQ-039 Reset asserted mid-flit SHALL discard the partial flit silently, with no frame_err_o pulse.
REQ-040 Buffered flits SHALL be lost on reset.

Verification
REQ-041 Single flit, byte i = i, correct framing, ready=1 -> flit_valid_o high 1 cycle after the 16th sample; flit_o byte i == i; err_count_o=0.
REQ-042 Two back-to-back flits (0xA5 fill, then 0x3C fill), ready=0 -> both buffered; a third flit -> overflow_o pulse; popping yields 0xA5 then 0x3C.
REQ-043 Valid pair 10 at g=1, p=1 -> frame_err_o pulse, err_count_o=1, no flit; the following correct flit is received intact.
REQ-044 Full buffer with ready=1 during the commit cycle -> no overflow; the new flit appears as the last entry.
REQ-045 Reset at g=2 -> receiving_o=0 next cycle, no flit, no error; the next flit is received normally.
REQ-046 300 consecutive framing errors -> err_count_o=255.
